fft_spec_buf_ctrl: RTL and testbench

- Ping-pong buffer controller between the FFT source (output) stream and the LCD spectrum display.
- Steers each N_POINTS-beat FFT output frame into one of two RAM banks.
- Hands completed banks to the display reader at display-frame boundaries, newest frame first.
- A bank being displayed is never written, and a bank being filled is never handed to the reader.

---
 rtl/fft_spec_buf_ctrl_if.sv | 34 +++
 rtl/fft_spec_buf_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_fft_spec_buf_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fft_spec_buf_ctrl_if.sv
// FFT spectrum buffer controller bus.
// Source stream, RAM write port and display handshake.
interface fft_spec_buf_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic              src_valid;
  logic              src_sop;
  logic              src_eop;
  logic [DATA_W-1:0] src_data;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              disp_frame_start;
  logic              rd_bank;
  logic              frame_avail;
  logic [7:0]        drop_cnt;
  logic [7:0]        err_cnt;

  modport master (
    output src_valid, src_sop, src_eop, src_data,
    output disp_frame_start,
    input  wr_en, wr_bank, wr_addr, wr_data,
    input  rd_bank, frame_avail, drop_cnt, err_cnt
  );

  modport slave (
    input  src_valid, src_sop, src_eop, src_data,
    input  disp_frame_start,
    output wr_en, wr_bank, wr_addr, wr_data,
    output rd_bank, frame_avail, drop_cnt, err_cnt
  );
endinterface

// File: rtl/fft_spec_buf_ctrl.sv
// Ping-pong bank controller: FFT frames into two RAM
// banks, completed banks handed to the LCD reader.
module fft_spec_buf_ctrl #(
  parameter int N_POINTS = 128,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16
) (
  input logic clk_50m,
  input logic rst,
  fft_spec_buf_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    B_FREE, B_FILLING, B_FULL, B_READING
  } bank_t;

  typedef enum logic {W_IDLE, W_FILL} wstate_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(N_POINTS - 1);

  bank_t             bst_q [2];
  bank_t             bst_d [2];
  wstate_t           ws_q, ws_d;
  logic              cur_q, cur_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              newest_q, newest_d;
  logic              rd_q, rd_d;
  logic              avail_q, avail_d;
  logic [7:0]        drop_q, err_q;

  logic              we_q, wbank_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              we;
  logic              wbank;
  logic [ADDR_W-1:0] waddr;
  logic              drop_inc, err_inc;
  logic              start, sel, take, have;

  // Reader update first, then writer on post-reader ownership
  always_comb begin
    bst_d    = bst_q;
    ws_d     = ws_q;
    cur_d    = cur_q;
    idx_d    = idx_q;
    newest_d = newest_q;
    rd_d     = rd_q;
    avail_d  = avail_q;
    we       = 1'b0;
    wbank    = cur_q;
    waddr    = '0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    start    = 1'b0;
    sel      = 1'b0;
    take     = 1'b0;
    have     = 1'b0;

    if (bus.disp_frame_start) begin
      if (!avail_q) begin
        have = (bst_q[0] == B_FULL) ||
               (bst_q[1] == B_FULL);
        if (bst_q[0] == B_FULL &&
            bst_q[1] == B_FULL)
          take = newest_q;
        else
          take = (bst_q[1] == B_FULL);
        if (have) begin
          bst_d[take] = B_READING;
          rd_d        = take;
          avail_d     = 1'b1;
        end
      end else if (bst_q[~rd_q] == B_FULL) begin
        bst_d[rd_q]  = B_FREE;
        bst_d[~rd_q] = B_READING;
        rd_d         = ~rd_q;
      end
    end

    if (bus.src_valid) begin
      unique case (ws_q)
        W_IDLE: start = bus.src_sop;
        W_FILL: begin
          if (bus.src_sop) begin
            err_inc      = 1'b1;
            bst_d[cur_q] = B_FREE;
            start        = 1'b1;
          end else if (idx_q == LAST) begin
            if (bus.src_eop) begin
              we           = 1'b1;
              waddr        = idx_q;
              bst_d[cur_q] = B_FULL;
              newest_d     = cur_q;
            end else begin
              bst_d[cur_q] = B_FREE;
              err_inc      = 1'b1;
            end
            ws_d = W_IDLE;
          end else if (bus.src_eop) begin
            bst_d[cur_q] = B_FREE;
            err_inc      = 1'b1;
            ws_d         = W_IDLE;
          end else begin
            we    = 1'b1;
            waddr = idx_q;
            idx_d = idx_q + 1'b1;
          end
        end
        default: ws_d = W_IDLE;
      endcase

      if (start) begin
        if (avail_d)
          sel = ~rd_d;
        else if (bst_d[0] == B_FULL &&
                 bst_d[1] == B_FULL)
          sel = ~newest_d;
        else
          sel = (bst_d[0] == B_FULL);
        drop_inc   = (bst_d[sel] == B_FULL);
        bst_d[sel] = B_FILLING;
        cur_d      = sel;
        wbank      = sel;
        idx_d      = ADDR_W'(1);
        ws_d       = W_FILL;
        we         = 1'b1;
        waddr      = '0;
      end
    end
  end

  // Bank/FSM state, counters and registered write port
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      bst_q[0] <= B_FREE;
      bst_q[1] <= B_FREE;
      ws_q     <= W_IDLE;
      cur_q    <= 1'b0;
      idx_q    <= '0;
      newest_q <= 1'b0;
      rd_q     <= 1'b0;
      avail_q  <= 1'b0;
      drop_q   <= '0;
      err_q    <= '0;
      we_q     <= 1'b0;
      wbank_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      bst_q    <= bst_d;
      ws_q     <= ws_d;
      cur_q    <= cur_d;
      idx_q    <= idx_d;
      newest_q <= newest_d;
      rd_q     <= rd_d;
      avail_q  <= avail_d;
      if (drop_inc && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
      if (err_inc && err_q != 8'hFF)
        err_q <= err_q + 8'd1;
      we_q <= we;
      if (we) begin
        wbank_q <= wbank;
        waddr_q <= waddr;
        wdata_q <= bus.src_data;
      end
    end
  end

  assign bus.wr_en       = we_q;
  assign bus.wr_bank     = wbank_q;
  assign bus.wr_addr     = waddr_q;
  assign bus.wr_data     = wdata_q;
  assign bus.rd_bank     = rd_q;
  assign bus.frame_avail = avail_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.err_cnt     = err_q;

endmodule

// File: tb/tb_fft_spec_buf_ctrl.sv
// Bench for fft_spec_buf_ctrl: frame table
// plus hand sequences for timing corner cases.
module tb_fft_spec_buf_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] seed = 16'h1234;

  always #10 clk = ~clk;

  fft_spec_buf_ctrl_if #(.ADDR_W(7), .DATA_W(16)) bus ();

  fft_spec_buf_ctrl #(
    .N_POINTS(128), .ADDR_W(7), .DATA_W(16)
  ) dut (
    .clk_50m(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int   kind;
    bit   bank;
    bit   pulse;
    bit   rd;
    bit   avail;
    int   drop;
    int   err;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic s,
                      input logic e, input logic dp,
                      input logic exp_we,
                      input logic exp_bank,
                      input logic [6:0] exp_addr);
    logic [15:0] d;
    d = seed;
    seed = seed * 16'd5 + 16'd7;
    @(negedge clk);
    bus.src_valid = v;
    bus.src_sop = s;
    bus.src_eop = e;
    bus.src_data = d;
    bus.disp_frame_start = dp;
    @(posedge clk);
    #1;
    if (exp_we)
      chk("write", {bus.wr_en, bus.wr_bank,
          bus.wr_addr, bus.wr_data},
          {1'b1, exp_bank, exp_addr, d});
    else
      chk("wr_en_off", 64'(bus.wr_en), 64'd0);
    if (bus.wr_en && bus.frame_avail)
      chk("bank_excl",
          64'(bus.wr_bank != bus.rd_bank), 64'd1);
  endtask

  task automatic frame(input bit b, input int eop_at,
                       input int pulse_at);
    for (int i = 0; i <= eop_at; i++)
      beat(1'b1, i == 0, i == eop_at, i == pulse_at,
           (eop_at == 127) || (i < eop_at), b, 7'(i));
  endtask

  task automatic partial(input bit b, input int n);
    for (int i = 0; i < n; i++)
      beat(1'b1, i == 0, 1'b0, 1'b0, 1'b1, b, 7'(i));
  endtask

  task automatic pulse();
    beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {bus.wr_en, bus.wr_bank, bus.wr_addr,
        bus.wr_data, bus.rd_bank, bus.frame_avail,
        bus.drop_cnt, bus.err_cnt}, 64'd0);
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    rst = 1'b1;
    bus.src_valid = v;
    bus.src_sop = 1'b0;
    bus.src_eop = 1'b0;
    bus.disp_frame_start = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("reset_clear");
    @(negedge clk);
    rst = 1'b0;
    bus.src_valid = 1'b0;
  endtask

  task automatic chk_rd(input string nm,
                        input bit rd, input bit av);
    chk(nm, {bus.rd_bank, bus.frame_avail},
        {rd, av});
  endtask

  initial begin
    bus.src_valid = 1'b0;
    bus.src_sop = 1'b0;
    bus.src_eop = 1'b0;
    bus.src_data = '0;
    bus.disp_frame_start = 1'b0;

    // kind: 0 clean, 1 eop@63, 2 sop@50, 3 reset
    tbl[0]  = '{0, 0, 1, 0, 1, 0, 0};
    tbl[1]  = '{0, 1, 1, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 1, 0, 0};
    tbl[4]  = '{3, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 1, 1, 0};
    tbl[8]  = '{3, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 1, 0, 0, 0, 1};
    tbl[10] = '{2, 0, 1, 0, 1, 0, 2};
    tbl[11] = '{0, 1, 1, 1, 1, 0, 2};

    repeat (3) @(posedge clk);
    #1;
    chk_reset("initial_reset");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      case (tbl[k].kind)
        0: frame(tbl[k].bank, 127, -1);
        1: frame(tbl[k].bank, 63, -1);
        2: begin
          partial(tbl[k].bank, 50);
          frame(tbl[k].bank, 127, -1);
        end
        default: do_reset(1'b0);
      endcase
      if (tbl[k].pulse) pulse();
      chk($sformatf("v%0d_rd", k),
          {bus.rd_bank, bus.frame_avail},
          {tbl[k].rd, tbl[k].avail});
      chk($sformatf("v%0d_drop", k),
          64'(bus.drop_cnt), 64'(tbl[k].drop));
      chk($sformatf("v%0d_err", k),
          64'(bus.err_cnt), 64'(tbl[k].err));
    end

    // Pulse on the eop beat must not see the new bank
    frame(1'b0, 127, 127);
    chk_rd("eop_pulse_hold", 1'b1, 1'b1);
    pulse();
    chk_rd("eop_pulse_swap", 1'b0, 1'b1);

    // Reset at beat 70 of a frame into bank 1
    partial(1'b1, 70);
    do_reset(1'b1);
    frame(1'b0, 127, -1);
    chk_rd("post_rst_noavail", 1'b0, 1'b0);
    pulse();
    chk_rd("post_rst_take", 1'b0, 1'b1);

    // Pulse on sop: swap first, writer uses new owner
    frame(1'b1, 127, -1);
    frame(1'b0, 127, 0);
    chk_rd("sop_pulse_swap", 1'b1, 1'b1);
    chk("sop_pulse_drop", 64'(bus.drop_cnt), 64'd0);

    @(negedge clk);
    bus.src_valid = 1'b0;
    bus.disp_frame_start = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
